// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scan driver:
// digit count, anode-off pattern, the display record layout and the
// per-digit helpers used when forming the decoder outputs.
package disp_pkg;

  localparam int NDIG = 4;

  // All anodes released (active-low selects, so all ones means dark).
  localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

  // One complete display setting as captured on a load strobe.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  points;
    logic [3:0]  blank_en;
    logic        lz_blank;
  } disp_rec_t;

  // Hex nibble shown on digit i (digit 0 is the rightmost).
  function automatic logic [3:0] nibble_at(input logic [15:0] d, input logic [1:0] i);
    nibble_at = d[4*i +: 4];
  endfunction

  // Leading-zero suppression: digit i goes dark when suppression is
  // enabled, it is not the units digit, and it and every digit to its
  // left are zero. The units digit always stays lit so zero reads "0".
  function automatic logic lz_sup(input disp_rec_t r, input logic [1:0] i);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (k >= int'(i) && r.data[4*k +: 4] != 4'h0) begin
        all_zero = 1'b0;
      end
    end
    lz_sup = r.lz_blank && (i != 2'd0) && all_zero;
  endfunction

endpackage

// File: rtl/scan_divider.sv
// Digit scan timebase: holds each digit for SCAN_DIV clocks, then steps
// the digit index 0..3 and wraps. tick marks the last clock of a digit.
module scan_divider #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [1:0] idx
);

  // A divide-by-one still needs a one-bit counter to stay well formed.
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  // Count clocks within a digit; on the final clock restart and advance the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode display fed through
// an MC14495 decoder. New values land in a shadow set and are promoted to
// the active set only at the end of a full scan, so a frame never mixes
// old and new digits.
module disp_scan_driver
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  points,
  input  logic [3:0]  blank_en,
  input  logic        lz_blank,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  logic       tick;
  logic [1:0] idx;
  logic       wrap;
  disp_rec_t  active;
  disp_rec_t  shadow;
  disp_rec_t  incoming;

  scan_divider #(
    .SCAN_DIV(SCAN_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .idx  (idx)
  );

  assign incoming = {data, points, blank_en, lz_blank};

  // The last clock of digit 3 closes the frame.
  assign wrap = tick && (idx == 2'd3);

  // Double buffer: a load at the frame boundary goes live immediately, other loads wait in shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (load && wrap) begin
      active  <= incoming;
      shadow  <= incoming;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= incoming;
      pending <= 1'b1;
    end else if (wrap && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  // Register the decoder and anode drive for the current digit, plus the end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex        <= 4'h0;
      point      <= 1'b0;
      le         <= 1'b1;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= ~(4'b0001 << idx);
      hex        <= nibble_at(active.data, idx);
      point      <= active.points[idx];
      le         <= active.blank_en[idx] | lz_sup(active, idx);
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_disp_scan_driver.sv
// Bench for disp_scan_driver: directed scenarios with literal expectations
// followed by randomized loads and resets, all compared every cycle
// against a frame-position model of the display.
module tb_disp_scan_driver;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  points = 4'h0;
  logic [3:0]  blank_en = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  hex;
  logic        point;
  logic        le;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  disp_scan_driver #(
    .SCAN_DIV(SD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .points     (points),
    .blank_en   (blank_en),
    .lz_blank   (lz_blank),
    .hex        (hex),
    .point      (point),
    .le         (le),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model state: active and shadow settings, edges since reset release.
  logic [15:0] m_data = 16'h0, s_data = 16'h0;
  logic [3:0]  m_pts = 4'h0, s_pts = 4'h0, m_blk = 4'h0, s_blk = 4'h0;
  logic        m_lz = 1'b0, s_lz = 1'b0, m_pend = 1'b0;
  int          n = 0;
  bit          model_ok = 1'b0;
  logic [3:0]  e_hex, e_an;
  logic        e_point, e_le, e_fd;

  // Expected outputs follow from the position of each edge within the frame.
  always @(posedge clk) begin
    int pos;
    int d;
    bit w;
    if (rst) begin
      m_data = 16'h0; m_pts = 4'h0; m_blk = 4'h0; m_lz = 1'b0;
      s_data = 16'h0; s_pts = 4'h0; s_blk = 4'h0; s_lz = 1'b0;
      m_pend = 1'b0;
      e_hex = 4'h0; e_point = 1'b0; e_le = 1'b1; e_an = 4'hF; e_fd = 1'b0;
      n = 0;
      model_ok = 1'b1;
    end else begin
      pos = n % FRAME;
      d = pos / SD;
      w = (pos == FRAME - 1);
      e_an = 4'hF;
      e_an[d] = 1'b0;
      e_hex = 4'((m_data >> (4 * d)) & 16'hF);
      e_point = m_pts[d];
      e_le = m_blk[d] || (m_lz && d != 0 && (m_data >> (4 * d)) == 16'h0);
      e_fd = w;
      if (load) begin
        s_data = data; s_pts = points; s_blk = blank_en; s_lz = lz_blank;
        if (w) begin
          m_data = data; m_pts = points; m_blk = blank_en; m_lz = lz_blank;
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end else if (w && m_pend) begin
        m_data = s_data; m_pts = s_pts; m_blk = s_blk; m_lz = s_lz;
        m_pend = 1'b0;
      end
      n++;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle after the first reset edge, all outputs must match the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("model an", 16'(an), 16'(e_an));
      checkOutput("model hex", 16'(hex), 16'(e_hex));
      checkOutput("model point", 16'(point), 16'(e_point));
      checkOutput("model le", 16'(le), 16'(e_le));
      checkOutput("model pending", 16'(pending), 16'(m_pend));
      checkOutput("model frame_done", 16'(frame_done), 16'(e_fd));
    end
  end

  // Advance until the most recent edge sat at frame position p.
  task automatic afterEdgePos(input int p);
    int guard;
    guard = 0;
    @(posedge clk); #2;
    while (((n - 1) % FRAME) != p && guard < 2 * FRAME) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame position %0d: got not reached expected reached", p);
    end
  endtask

  // One-cycle load strobe, then scramble the bus to show it is ignored.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] b, input logic lz);
    data = d; points = p; blank_en = b; lz_blank = lz;
    load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    data = 16'($urandom); points = 4'($urandom);
    blank_en = 4'($urandom); lz_blank = 1'($urandom);
  endtask

  task automatic expectDigit(input string tag, input logic [3:0] x_an, input logic [3:0] x_hex,
                             input logic x_point, input logic x_le);
    checkOutput({tag, " an"}, 16'(an), 16'(x_an));
    checkOutput({tag, " hex"}, 16'(hex), 16'(x_hex));
    checkOutput({tag, " point"}, 16'(point), 16'(x_point));
    checkOutput({tag, " le"}, 16'(le), 16'(x_le));
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #2;
    expectDigit("in reset", 4'b1111, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk); #2;
    expectDigit("first scan", 4'b1110, 4'h0, 1'b0, 1'b0);
    afterEdgePos(4);
    expectDigit("idle d1", 4'b1101, 4'h0, 1'b0, 1'b0);
    afterEdgePos(15);
    checkOutput("frame_done pulse", 16'(frame_done), 16'h1);
    @(posedge clk); #2;
    checkOutput("frame_done low", 16'(frame_done), 16'h0);

    // Mid-frame load waits for the frame boundary.
    afterEdgePos(5);
    applyStimulus(16'h1A2F, 4'b0101, 4'b0000, 1'b0);
    checkOutput("basic pending", 16'(pending), 16'h1);
    afterEdgePos(14);
    checkOutput("basic still pending", 16'(pending), 16'h1);
    afterEdgePos(15);
    checkOutput("basic promoted", 16'(pending), 16'h0);
    afterEdgePos(0);
    expectDigit("basic d0", 4'b1110, 4'hF, 1'b1, 1'b0);
    afterEdgePos(4);
    expectDigit("basic d1", 4'b1101, 4'h2, 1'b0, 1'b0);
    afterEdgePos(8);
    expectDigit("basic d2", 4'b1011, 4'hA, 1'b1, 1'b0);
    afterEdgePos(12);
    expectDigit("basic d3", 4'b0111, 4'h1, 1'b0, 1'b0);

    // Load landing exactly on the wrap edge goes live with no pending phase.
    afterEdgePos(14);
    applyStimulus(16'h00C3, 4'b0000, 4'b0000, 1'b0);
    checkOutput("wrap load pending", 16'(pending), 16'h0);
    afterEdgePos(0);
    expectDigit("wrap d0", 4'b1110, 4'h3, 1'b0, 1'b0);
    afterEdgePos(4);
    expectDigit("wrap d1", 4'b1101, 4'hC, 1'b0, 1'b0);
    afterEdgePos(8);
    expectDigit("wrap d2", 4'b1011, 4'h0, 1'b0, 1'b0);

    // Two loads before the boundary: the later one wins.
    afterEdgePos(1);
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
    afterEdgePos(0);
    expectDigit("double d0", 4'b1110, 4'h2, 1'b0, 1'b0);
    afterEdgePos(12);
    expectDigit("double d3", 4'b0111, 4'h2, 1'b0, 1'b0);

    // Leading-zero suppression.
    afterEdgePos(3);
    applyStimulus(16'h0040, 4'b0000, 4'b0000, 1'b1);
    afterEdgePos(0);
    expectDigit("lz d0", 4'b1110, 4'h0, 1'b0, 1'b0);
    afterEdgePos(4);
    expectDigit("lz d1", 4'b1101, 4'h4, 1'b0, 1'b0);
    afterEdgePos(8);
    expectDigit("lz d2", 4'b1011, 4'h0, 1'b0, 1'b1);
    afterEdgePos(12);
    expectDigit("lz d3", 4'b0111, 4'h0, 1'b0, 1'b1);
    afterEdgePos(3);
    applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
    afterEdgePos(0);
    expectDigit("lz zero d0", 4'b1110, 4'h0, 1'b0, 1'b0);
    afterEdgePos(4);
    expectDigit("lz zero d1", 4'b1101, 4'h0, 1'b0, 1'b1);

    // Forced blank keeps hex and point driven.
    afterEdgePos(3);
    applyStimulus(16'h5678, 4'b0010, 4'b0010, 1'b0);
    afterEdgePos(0);
    expectDigit("blank d0", 4'b1110, 4'h8, 1'b0, 1'b0);
    afterEdgePos(4);
    expectDigit("blank d1", 4'b1101, 4'h7, 1'b1, 1'b1);

    // Reset while a value is pending discards it.
    afterEdgePos(5);
    applyStimulus(16'h9ABC, 4'b1111, 4'b0000, 1'b0);
    checkOutput("pre-reset pending", 16'(pending), 16'h1);
    rst = 1'b1;
    @(posedge clk); #2;
    checkOutput("reset pending", 16'(pending), 16'h0);
    expectDigit("reset outputs", 4'b1111, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    afterEdgePos(0);
    expectDigit("post-reset d0", 4'b1110, 4'h0, 1'b0, 1'b0);
    afterEdgePos(15);
    afterEdgePos(0);
    expectDigit("discarded d0", 4'b1110, 4'h0, 1'b0, 1'b0);
    afterEdgePos(8);
    expectDigit("discarded d2", 4'b1011, 4'h0, 1'b0, 1'b0);

    // Randomized loads and occasional resets.
    for (int i = 0; i < 900; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 5) == 0);
      data = 16'($urandom);
      points = 4'($urandom);
      blank_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_blank = 1'($urandom);
      if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
      @(posedge clk); #2;
    end
    rst = 1'b0;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Upper bound on run time.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_driver.md
Name: disp_scan_driver

Overview:
Time-multiplexed driver for a 4-digit common-anode 7-segment display built from the MC14495 hex-to-7-segment decoder. Holds a 16-bit hex value plus per-digit decimal points, and scans one digit at a time. For each active digit it drives the decoder inputs (D3..D0, point, LE) and the matching active-low anode select. New values are double-buffered so the display only updates at frame boundaries, which prevents tearing.

Parameters:
SCAN_DIV, 4, clk cycles each digit stays active; legal range >= 1; the divider counter is $clog2(SCAN_DIV) bits wide, minimum 1 bit.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
load  input  1  one-cycle strobe; captures data/points/blank_en/lz_blank.
data  input  16  hex value; digit k = data[4k+3:4k]; digit 0 is the rightmost.
points  input  4  decimal point enable per digit, active-high.
blank_en  input  4  force-blank per digit, active-high.
lz_blank  input  1  enable leading-zero suppression.
hex  output  4  to decoder {D3,D2,D1,D0}.
point  output  1  to decoder point input, active-high.
le  output  1  to decoder LE; 1 = digit blanked.
an  output  4  anode selects, active-low, one-hot-zero.
pending  output  1  a captured value is waiting for the next frame boundary.
frame_done  output  1  one-cycle pulse when digit 3 finishes.

Behaviour:
- State: div_cnt, idx (2 bits), active register set (data/points/blank_en/lz_blank), shadow register set, pending flag.
- Reset values: div_cnt=0, idx=0, active=0, shadow=0, pending=0. Outputs: hex=0, point=0, le=1, an=4'b1111, frame_done=0.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - tick = (div_cnt==SCAN_DIV-1). On tick, div_cnt goes to 0 and idx goes to idx+1 mod 4.
  - SCAN_DIV=1 means idx advances every cycle.
- wrap = tick && idx==3.
- frame_done is registered: it is 1 in the cycle after each wrap edge.
- Load handling, in priority order:
  - load && wrap: active <= input bus directly; pending stays/becomes 0; shadow <= input bus.
  - load only: shadow <= input bus; pending <= 1. A load while already pending overwrites shadow (last write wins).
  - wrap && pending (no load): active <= shadow; pending <= 0.
- Output register: outputs are registered from the current idx and active set, giving 1-cycle latency after an idx change.
  - an = ~(4'b0001 << idx).
  - hex = active nibble for idx.
  - point = active.points[idx].
  - le = active.blank_en[idx] OR lz_sup(idx).
- lz_sup(idx):
  - 1 iff active.lz_blank, idx != 0, and all nibbles idx..3 are zero.
  - Digit 0 is never suppressed, so value 0 shows as "0".
- point is driven independently of le: a blanked digit still outputs its point bit; the decoder's LE governs visibility.
- After rst deasserts: first output cycle has an=4'b1110 and le reflects active=0 (le=0, hex=0). The full scan then repeats every 4*SCAN_DIV cycles.
- rst mid-frame: all state returns to reset values on the next edge; a pending shadow value is discarded.
- Inputs are sampled only on load; changes to data between loads have no effect.

Decomposition:
- Shared package disp_pkg:
  - NDIG=4.
  - Anode-off constant AN_OFF=4'b1111.
  - Typedef of the display record {data[15:0], points[3:0], blank_en[3:0], lz_blank}.
- One natural sub-module: scan_divider (parameter SCAN_DIV; outputs tick and idx). All remaining logic stays in the top block.

Test Plan:
- Reset/idle (SCAN_DIV=4): rst high 3 cycles, then low -> during rst an=1111, le=1. Then an steps 1110 -> 1101 -> 1011 -> 0111, 4 cycles each, hex=0. frame_done pulses every 16 cycles.
- Basic load: load data=16'h1A2F, points=4'b0101 mid-frame -> pending=1 until the wrap, then pending=0. Next frame shows hex F,2,A,1 on an 1110,1101,1011,0111, with point 1,0,1,0.
- Load coinciding with wrap: assert load on the idx=3/div_cnt=3 edge with data=16'h00C3 -> the very next frame shows 3,C,0,0 and pending never goes to 1.
- Double load while pending: load 16'h1111, then 16'h2222 before the wrap -> the frame shows 2222 only.
- Leading-zero blank: load data=16'h0040, lz_blank=1 -> digit 0 le=0 hex 0; digit 1 le=0 hex 4; digits 2 and 3 le=1. With data=16'h0000 -> only digit 0 unblanked.
- Force blank and mid-frame reset: blank_en=4'b0010 -> digit 1 le=1 with hex still driven. Assert rst while pending=1 -> pending cleared, outputs return to reset values, and the old value remains discarded after release.
